// File: rtl/hilo_multiply_unit.sv
// Hi/Lo multiply unit: iterative MULT/MULTU/MADD/MSUB plus single-cycle MTHI/MTLO.
// Define FAST_MULT_EN to replace the shift-add MUL phase with a combinational multiply.
module hilo_multiply_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  // Handshake: Start is a one-cycle request taken only while Busy=0; a request
  // seen while Busy=1 is dropped. Done pulses once after Hi/Lo commit.

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t                 state;
  state_t                 stateNext;
  logic [WIDTH-1:0]       mcand;
  logic [2*WIDTH-1:0]     prod;
  logic [1:0]             opReg;
  logic                   sign;
  logic                   opSigned;
  logic                   startMul;
  logic [WIDTH-1:0]       absA;
  logic [WIDTH-1:0]       absB;
  logic [2*WIDTH-1:0]     magnitude;
  logic [2*WIDTH-1:0]     signedProd;

`ifdef FAST_MULT_EN
  always_comb begin
    magnitude = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
  end
`else
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]          count;
  logic [WIDTH:0]         partialSum;

  // Upper half accumulates the multiplicand; lower half holds the shifting multiplier.
  always_comb begin
    partialSum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    magnitude  = prod;
  end
`endif

  always_comb begin
    startMul   = Start && (Op[2] == 1'b0);
    opSigned   = (Op != 3'b001);
    absA       = (opSigned && A[WIDTH-1]) ? -A : A;
    absB       = (opSigned && B[WIDTH-1]) ? -B : B;
    signedProd = sign ? -magnitude : magnitude;
    Busy       = (state != IDLE);
    Stall      = Busy;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
`ifdef FAST_MULT_EN
        if (startMul) stateNext = FIN;
`else
        if (startMul) stateNext = MUL;
`endif
      end
`ifdef FAST_MULT_EN
      MUL: stateNext = IDLE;
`else
      MUL: if (count == CW'(WIDTH - 1)) stateNext = FIN;
`endif
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hi    <= '0;
      Lo    <= '0;
      Done  <= 1'b0;
      mcand <= '0;
      prod  <= '0;
      opReg <= '0;
      sign  <= 1'b0;
`ifndef FAST_MULT_EN
      count <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            case (Op)
              3'b100: Hi <= A;
              3'b101: Lo <= A;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                mcand <= absA;
                prod  <= {{WIDTH{1'b0}}, absB};
                opReg <= Op[1:0];
                sign  <= opSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifndef FAST_MULT_EN
                count <= '0;
`endif
              end
              default: ;
            endcase
          end
        end
`ifndef FAST_MULT_EN
        MUL: begin
          prod  <= {partialSum, prod[WIDTH-1:1]};
          count <= count + 1'b1;
        end
`endif
        FIN: begin
          case (opReg)
            2'b10:   {Hi, Lo} <= {Hi, Lo} + signedProd;
            2'b11:   {Hi, Lo} <= {Hi, Lo} - signedProd;
            default: {Hi, Lo} <= signedProd;
          endcase
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
